// File: rtl/allpass_pkg.sv
// Shared definitions for the polyphase allpass filter stages:
// default sample width, saturation limits and round-half-up/saturate helper.
package allpass_pkg;

    localparam int unsigned WIDTH = 16;

    function automatic logic signed [63:0] smax(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Halve with round-half-up (caller has already added the +1), then clamp to w bits.
    function automatic logic signed [63:0] sat_round_half(input logic signed [63:0] s,
                                                          input int unsigned w);
        logic signed [63:0] r;
        r = s >>> 1;
        if (r > smax(w))
            return smax(w);
        else if (r < smin(w))
            return smin(w);
        else
            return r;
    endfunction

endpackage

// File: rtl/allpass_decim_combiner_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty     = (r_level == '0);
    assign full      = (r_level == (AW + 1)'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = empty ? '0 : r_mem[r_rptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)
                r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop_ok)
                r_level <= r_level + 1'b1;
            else if (!w_push_ok && w_pop_ok)
                r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/allpass_decim_combiner.sv
// Combines the two allpass branches (sum or difference), rounds, saturates,
// decimates by 2 and buffers results in an output FIFO with drop accounting.
module allpass_decim_combiner
    import allpass_pkg::*;
#(
    parameter int unsigned WIDTH      = allpass_pkg::WIDTH,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              br0,
    input  logic [WIDTH-1:0]              br1,
    input  logic                          hp_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_count,
    input  logic                          clr_ovf
);
    logic                      r_ph;
    logic                      r_s1_v;
    // Two guard bits: br0=max minus br1=min plus the rounding 1 needs WIDTH+2 to stay exact.
    logic signed [WIDTH+1:0]   r_s1;
    logic signed [WIDTH+1:0]   w_a;
    logic signed [WIDTH+1:0]   w_b;
    logic signed [WIDTH+1:0]   w_sum;
    logic [WIDTH-1:0]          w_res;
    logic                      w_keep;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_drop;
    logic                      r_ovf;
    logic [CNT_W-1:0]          r_drop_cnt;

    assign w_keep = in_valid && r_ph;
    assign w_a    = {{2{br0[WIDTH-1]}}, br0};
    assign w_b    = {{2{br1[WIDTH-1]}}, br1};
    assign w_sum  = hp_sel ? (w_a - w_b + (WIDTH + 2)'(1)) : (w_a + w_b + (WIDTH + 2)'(1));
    assign w_res  = WIDTH'(sat_round_half(64'(r_s1), WIDTH));

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = r_s1_v && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph   <= 1'b0;
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else begin
            if (in_valid)
                r_ph <= !r_ph;
            r_s1_v <= w_keep;
            if (w_keep)
                r_s1 <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_ovf) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign overflow   = r_ovf;
    assign drop_count = r_drop_cnt;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_s1_v),
        .din   (w_res),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (out_data),
        .empty (w_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_allpass_decim_combiner.sv
// Directed bench for allpass_decim_combiner: table of single-result vectors
// plus hand sequences for latency, overflow, full+pop and mid-stream reset.
module tb_allpass_decim_combiner;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [15:0]        br0;
    logic [15:0]        br1;
    logic               hp_sel;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic [3:0]         fifo_level;
    logic               overflow;
    logic [15:0]        drop_count;
    logic               clr_ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int b0;
        int b1;
        bit hp;
        int exp;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    allpass_decim_combiner #(
        .WIDTH      (16),
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .br0        (br0),
        .br1        (br1),
        .hp_sel     (hp_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_ovf    (clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int b0, input int b1, input bit v);
        br0      = 16'(b0);
        br1      = 16'(b1);
        in_valid = v;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; br0 = '0; br1 = '0; hp_sel = 1'b0;
        out_ready = 1'b1; clr_ovf = 1'b0;

        vecs[0] = '{1000,   201,    1'b0, 601};
        vecs[1] = '{1000,   201,    1'b1, 400};
        vecs[2] = '{32767,  -32768, 1'b1, 32767};
        vecs[3] = '{32767,  -32768, 1'b0, 0};
        vecs[4] = '{-32768, -32768, 1'b0, -32768};
        vecs[5] = '{-3,     0,      1'b0, -1};
        vecs[6] = '{-32768, 32767,  1'b1, -32767};
        vecs[7] = '{5,      2,      1'b1, 2};

        tick(); tick();
        rst = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", $signed(out_data), 0);
        chk("reset fifo_level", fifo_level, 0);
        chk("reset overflow", overflow, 0);
        chk("reset drop_count", drop_count, 0);

        // Table vectors: discard sample, keep sample, then watch the 2-clock latency.
        foreach (vecs[i]) begin
            hp_sel = vecs[i].hp;
            drive(7, 7, 1'b1);              tick();
            drive(vecs[i].b0, vecs[i].b1, 1'b1); tick();
            drive(0, 0, 1'b0);
            chk($sformatf("vec%0d not yet valid", i), out_valid, 0);
            tick();
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d data", i), $signed(out_data), vecs[i].exp);
            tick();
            chk($sformatf("vec%0d drained", i), out_valid, 0);
        end

        // Four consecutive lowpass samples -> two results of 601.
        hp_sel = 1'b0;
        drive(1000, 201, 1'b1);
        tick(); tick(); tick();
        chk("seq1 first valid", out_valid, 1);
        chk("seq1 first data", $signed(out_data), 601);
        tick();
        drive(0, 0, 1'b0);
        chk("seq1 gap", out_valid, 0);
        tick();
        chk("seq1 second valid", out_valid, 1);
        chk("seq1 second data", $signed(out_data), 601);
        tick();

        // hp_sel change after the keep sample must not affect the pending result.
        hp_sel = 1'b1;
        drive(1000, 201, 1'b1); tick(); tick();
        hp_sel = 1'b0;
        drive(0, 0, 1'b0); tick();
        chk("hp_sel pipelined", $signed(out_data), 400);
        tick();

        // Overflow: 20 samples with no consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(i, 0, 1'b1); tick();
        end
        drive(0, 0, 1'b0); tick(); tick();
        chk("ovf level", fifo_level, 8);
        chk("ovf flag", overflow, 1);
        chk("ovf drop_count", drop_count, 2);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf drain%0d valid", k), out_valid, 1);
            chk($sformatf("ovf drain%0d data", k), $signed(out_data), k + 1);
            tick();
        end
        chk("ovf drained", out_valid, 0);
        chk("ovf drained level", fifo_level, 0);
        chk("ovf sticky", overflow, 1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("clr overflow", overflow, 0);
        chk("clr drop_count", drop_count, 0);

        // Full FIFO, write and pop on the same edge.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(10 * i, 0, 1'b1); tick();
        end
        drive(0, 0, 1'b0); tick();
        chk("full level", fifo_level, 8);
        drive(1, 1, 1'b1); tick();
        drive(50, 0, 1'b1); tick();
        drive(0, 0, 1'b0); out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("full+pop level", fifo_level, 8);
        chk("full+pop drop_count", drop_count, 0);
        chk("full+pop overflow", overflow, 0);
        chk("full+pop head", $signed(out_data), 15);

        // Drain, then reset mid-stream with 5 entries and ph=1.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(2 * i, 0, 1'b1); tick();
        end
        drive(0, 0, 1'b0); tick(); tick();
        chk("pre-reset level", fifo_level, 5);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("post-reset out_valid", out_valid, 0);
        chk("post-reset out_data", $signed(out_data), 0);
        chk("post-reset level", fifo_level, 0);
        drive(100, 0, 1'b1); tick();
        drive(200, 0, 1'b1); tick();
        drive(0, 0, 1'b0); tick(); tick(); tick();
        chk("post-reset one output", fifo_level, 1);
        chk("post-reset data", $signed(out_data), 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
